// File: rtl/tomasulo_pkg.sv
// Shared types for the Tomasulo issue/execute loop: CDB broadcast, issue request
// and the dispatch payload written into reservation-station entries.
package tomasulo_pkg;

  localparam int RS_N_DEFAULT = 4;
  localparam int WORD_W       = 8;
  localparam int TAG_W        = 4;
  localparam int ROB_W        = 4;
  localparam int WA_W         = 3;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [ROB_W-1:0]  robid_t;
  typedef logic [WA_W-1:0]   wa_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOT  = 4'd5,
    OP_MOV0 = 4'd6,
    OP_MOV1 = 4'd7,
    OP_MOVI = 4'd8
  } opcode_t;

  typedef struct packed {
    logic   vld;
    tag_t   tag;
    word_t  wdata;
    robid_t robid;
    wa_t    wa;
  } cdb_t;

  typedef struct packed {
    opcode_t     op;
    word_t [1:0] rdata;
    word_t       imm;
    tag_t        tag;
    robid_t      robid;
    wa_t         wa;
  } issue_t;

  typedef struct packed {
    opcode_t     op;
    word_t       imm;
    robid_t      robid;
    wa_t         wa;
    tag_t        tag;
    logic [1:0]  rdy;
    tag_t [1:0]  src_tag;
    word_t [1:0] rdata;
  } dispatch_t;

  function automatic issue_t to_issue(input dispatch_t e);
    issue_t r;
    r       = '0;
    r.op    = e.op;
    r.rdata = e.rdata;
    r.imm   = e.imm;
    r.tag   = e.tag;
    r.robid = e.robid;
    r.wa    = e.wa;
    return r;
  endfunction

endpackage

// File: rtl/tomasulo_rs_age_matrix.sv
// N x N age matrix: age_q[r][c]=1 means entry r is older than entry c.
// Grants the single oldest requester.
module tomasulo_rs_age_matrix #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] alloc_i,
  input  logic [N-1:0] valid_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] grant_o
);

  logic [N-1:0] age_q [N];
  logic [N-1:0] age_d [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_row
      logic [N-1:0] col;

      // A new entry is younger than everything currently valid
      always_comb begin
        age_d[gi] = age_q[gi];
        if (alloc_i[gi]) begin
          age_d[gi] = '0;
        end else begin
          for (int c = 0; c < N; c++) begin
            if (alloc_i[c]) age_d[gi][c] = valid_i[gi];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) age_q[gi] <= '0;
        else     age_q[gi] <= age_d[gi];
      end

      always_comb begin
        col = '0;
        for (int r = 0; r < N; r++) col[r] = age_q[r][gi];
      end

      assign grant_o[gi] = req_i[gi] & ~|(req_i & col);
    end
  endgenerate

endmodule

// File: rtl/tomasulo_rs.sv
// Reservation station: holds dispatched ops until both operands arrive (via
// dispatch, CDB bypass or CDB wakeup) and issues the oldest ready entry.
module tomasulo_rs
  import tomasulo_pkg::*;
#(
  parameter int N     = RS_N_DEFAULT,
  parameter int CNT_W = $clog2(N+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             disp_vld,
  input  dispatch_t        disp,
  output logic             disp_full_r,
  input  cdb_t             cdb,
  output logic             iss_vld,
  output issue_t           iss,
  input  logic             iss_busy,
  output logic [CNT_W-1:0] occ_r
);

  logic             vld_q [N];
  logic             vld_d [N];
  dispatch_t        ent_q [N];
  dispatch_t        ent_d [N];
  logic [N-1:0]     vld_vec;
  logic [N-1:0]     ready;
  logic [N-1:0]     grant;
  logic [N-1:0]     alloc_oh;
  logic [N-1:0]     free_oh;
  logic             accept;
  logic             xfer;
  dispatch_t        disp_byp;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             full_q, full_d;
  logic             unused_cdb;

  assign unused_cdb = ^{cdb.robid, cdb.wa};

  assign accept = disp_vld & ~full_q;

  // Operand broadcast in the accepting cycle is captured directly
  always_comb begin
    disp_byp = disp;
    for (int k = 0; k < 2; k++) begin
      if (!disp.rdy[k] && cdb.vld && (cdb.tag == disp.src_tag[k])) begin
        disp_byp.rdy[k]   = 1'b1;
        disp_byp.rdata[k] = cdb.wdata;
      end
    end
  end

  always_comb begin
    logic found;
    found    = 1'b0;
    alloc_oh = '0;
    for (int i = 0; i < N; i++) begin
      if (!vld_q[i] && !found) begin
        alloc_oh[i] = accept;
        found       = 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ent
      always_comb begin
        vld_d[gi] = vld_q[gi];
        ent_d[gi] = ent_q[gi];
        if (alloc_oh[gi]) begin
          vld_d[gi] = 1'b1;
          ent_d[gi] = disp_byp;
        end else begin
          if (free_oh[gi]) vld_d[gi] = 1'b0;
          for (int k = 0; k < 2; k++) begin
            if (vld_q[gi] && !ent_q[gi].rdy[k] && cdb.vld &&
                (cdb.tag == ent_q[gi].src_tag[k])) begin
              ent_d[gi].rdy[k]   = 1'b1;
              ent_d[gi].rdata[k] = cdb.wdata;
            end
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q[gi] <= 1'b0;
          ent_q[gi] <= '0;
        end else begin
          vld_q[gi] <= vld_d[gi];
          ent_q[gi] <= ent_d[gi];
        end
      end

      assign vld_vec[gi] = vld_q[gi];
      assign ready[gi]   = vld_q[gi] & ent_q[gi].rdy[0] & ent_q[gi].rdy[1];
    end
  endgenerate

  tomasulo_rs_age_matrix #(.N(N)) u_age (
    .clk     (clk),
    .rst     (rst),
    .alloc_i (alloc_oh),
    .valid_i (vld_vec),
    .req_i   (ready),
    .grant_o (grant)
  );

  assign iss_vld = |ready;
  assign xfer    = iss_vld & ~iss_busy;
  assign free_oh = grant & {N{xfer}};

  always_comb begin
    iss = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) iss = to_issue(ent_q[i]);
    end
  end

  always_comb begin
    occ_d  = occ_q + CNT_W'(accept) - CNT_W'(xfer);
    full_d = (occ_d == CNT_W'(N));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q  <= '0;
      full_q <= 1'b0;
    end else begin
      occ_q  <= occ_d;
      full_q <= full_d;
    end
  end

  assign occ_r       = occ_q;
  assign disp_full_r = full_q;

endmodule

// File: tb/tb_tomasulo_rs.sv
// Directed bench for tomasulo_rs: ready issue, wakeup, bypass, full/backpressure,
// age ordering with refill, and mid-operation reset.
module tb_tomasulo_rs;
  import tomasulo_pkg::*;

  localparam int N     = 4;
  localparam int CNT_W = $clog2(N+1);

  logic             clk = 1'b0;
  logic             rst;
  logic             disp_vld;
  dispatch_t        disp;
  logic             disp_full_r;
  cdb_t             cdb;
  logic             iss_vld;
  issue_t           iss;
  logic             iss_busy;
  logic [CNT_W-1:0] occ_r;

  int   n_cmp   = 0;
  int   n_mis   = 0;
  logic drop_ok = 1'b0;

  always #5 clk = ~clk;

  tomasulo_rs #(.N(N), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .disp_vld    (disp_vld),
    .disp        (disp),
    .disp_full_r (disp_full_r),
    .cdb         (cdb),
    .iss_vld     (iss_vld),
    .iss         (iss),
    .iss_busy    (iss_busy),
    .occ_r       (occ_r)
  );

  always @(posedge clk) begin
    if (!rst && !drop_ok)
      assert (!(disp_vld && disp_full_r)) else $error("protocol: dispatch while full");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_disp(input opcode_t op, input tag_t tag, input logic [1:0] rdy,
                          input tag_t st1, input tag_t st0, input word_t d1, input word_t d0);
    disp            = '0;
    disp.op         = op;
    disp.tag        = tag;
    disp.rdy        = rdy;
    disp.src_tag[1] = st1;
    disp.src_tag[0] = st0;
    disp.rdata[1]   = d1;
    disp.rdata[0]   = d0;
    disp_vld        = 1'b1;
    $display("dispatch tag=%0d rdy=%b src=%0d/%0d", tag, rdy, st1, st0);
  endtask

  task automatic set_cdb(input tag_t t, input word_t w);
    cdb       = '0;
    cdb.vld   = 1'b1;
    cdb.tag   = t;
    cdb.wdata = w;
    $display("cdb tag=%0d wdata=0x%0h", t, w);
  endtask

  task automatic idle();
    disp_vld = 1'b0;
    disp     = '0;
    cdb      = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    iss_busy = 1'b0;
    idle();
    tick();
    tick();
    check("rst_occ", occ_r, 0);
    check("rst_full", disp_full_r, 0);
    check("rst_vld", iss_vld, 0);
    check("rst_iss", (iss == '0), 1);
    rst = 1'b0;
    tick();
    check("post_rst_vld", iss_vld, 0);

    // Ready dispatch
    set_disp(OP_AND, 4'd5, 2'b11, 4'd0, 4'd0, 8'h3C, 8'hF0);
    tick();
    idle();
    check("rdy_vld", iss_vld, 1);
    check("rdy_tag", iss.tag, 5);
    check("rdy_op", iss.op, OP_AND);
    check("rdy_d1", iss.rdata[1], 8'h3C);
    check("rdy_d0", iss.rdata[0], 8'hF0);
    check("rdy_occ", occ_r, 1);
    tick();
    check("rdy_done_vld", iss_vld, 0);
    check("rdy_done_occ", occ_r, 0);

    // Wakeup via CDB, non-matching tag first
    set_disp(OP_ADD, 4'd6, 2'b10, 4'd0, 4'd3, 8'h11, 8'h00);
    tick();
    idle();
    check("wk_wait_vld", iss_vld, 0);
    set_cdb(4'd4, 8'h99);
    tick();
    check("wk_nomatch_vld", iss_vld, 0);
    set_cdb(4'd3, 8'hAA);
    #1;
    check("wk_same_cycle_vld", iss_vld, 0);
    tick();
    idle();
    check("wk_vld", iss_vld, 1);
    check("wk_tag", iss.tag, 6);
    check("wk_d0", iss.rdata[0], 8'hAA);
    check("wk_d1", iss.rdata[1], 8'h11);
    tick();
    check("wk_done_occ", occ_r, 0);

    // Dispatch/CDB bypass
    set_disp(OP_OR, 4'd8, 2'b01, 4'd7, 4'd0, 8'h00, 8'h22);
    set_cdb(4'd7, 8'h55);
    tick();
    idle();
    check("byp_vld", iss_vld, 1);
    check("byp_tag", iss.tag, 8);
    check("byp_d1", iss.rdata[1], 8'h55);
    check("byp_d0", iss.rdata[0], 8'h22);
    tick();
    check("byp_done_occ", occ_r, 0);
    check("byp_done_vld", iss_vld, 0);

    // Full / backpressure
    iss_busy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      set_disp(OP_ADD, tag_t'(i), 2'b11, 4'd0, 4'd0, 8'(i), 8'(i));
      tick();
      check("full_occ", occ_r, i);
    end
    check("full_flag", disp_full_r, 1);
    check("full_head", iss.tag, 1);
    drop_ok = 1'b1;
    set_disp(OP_ADD, 4'd9, 2'b11, 4'd0, 4'd0, 8'h09, 8'h09);
    tick();
    drop_ok = 1'b0;
    idle();
    check("drop_occ", occ_r, 4);
    check("drop_full", disp_full_r, 1);
    iss_busy = 1'b0;
    tick();
    check("drain1_occ", occ_r, 3);
    check("drain1_full", disp_full_r, 0);
    check("drain1_tag", iss.tag, 2);
    tick();
    check("drain2_tag", iss.tag, 3);
    tick();
    check("drain3_tag", iss.tag, 4);
    check("drain3_occ", occ_r, 1);
    tick();
    check("drain_done_vld", iss_vld, 0);
    check("drain_done_occ", occ_r, 0);

    // Age order: A not ready, B and C ready; wake A as B issues, refill entry 1
    iss_busy = 1'b1;
    set_disp(OP_SUB, 4'd10, 2'b10, 4'd0, 4'd9, 8'h01, 8'h00);
    tick();
    set_disp(OP_XOR, 4'd11, 2'b11, 4'd0, 4'd0, 8'h02, 8'h02);
    tick();
    set_disp(OP_XOR, 4'd12, 2'b11, 4'd0, 4'd0, 8'h03, 8'h03);
    tick();
    idle();
    check("age_first", iss.tag, 11);
    iss_busy = 1'b0;
    set_cdb(4'd9, 8'h77);
    tick();
    idle();
    check("age_second", iss.tag, 10);
    check("age_wake_d0", iss.rdata[0], 8'h77);
    set_disp(OP_MOVI, 4'd13, 2'b11, 4'd0, 4'd0, 8'h04, 8'h04);
    tick();
    idle();
    check("age_third", iss.tag, 12);
    check("age_occ", occ_r, 2);
    tick();
    check("age_refill_last", iss.tag, 13);
    tick();
    check("age_done_vld", iss_vld, 0);
    check("age_done_occ", occ_r, 0);

    // Reset mid-operation
    iss_busy = 1'b1;
    set_disp(OP_ADD, 4'd1, 2'b10, 4'd0, 4'd12, 8'h05, 8'h00);
    tick();
    set_disp(OP_ADD, 4'd2, 2'b11, 4'd0, 4'd0, 8'h06, 8'h06);
    tick();
    set_disp(OP_ADD, 4'd3, 2'b11, 4'd0, 4'd0, 8'h07, 8'h07);
    tick();
    idle();
    check("mrst_pre_occ", occ_r, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_occ", occ_r, 0);
    check("mrst_full", disp_full_r, 0);
    check("mrst_vld", iss_vld, 0);
    iss_busy = 1'b0;
    set_cdb(4'd12, 8'hEE);
    tick();
    idle();
    check("mrst_cdb_vld", iss_vld, 0);
    tick();
    check("mrst_cdb_vld2", iss_vld, 0);
    check("mrst_cdb_occ", occ_r, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/tomasulo_rs.md
Name: tomasulo_rs

Overview:
- Reservation station that feeds one tomasulo_exe_logic instance, on the issue side of the CDB loop.
- Accepts dispatched instructions and holds them until both operands are ready.
- Snoops the CDB to capture pending operands, then issues the oldest ready entry to the execution unit over the issue_t interface.
- Consumer of CDB broadcasts and producer of issue requests; together with the exe logic it closes the loop.

Parameters:
- N, 4, number of RS entries (N >= 2).
- CNT_W, $clog2(N+1), occupancy counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- disp_vld  in  1  dispatch request
- disp  in  dispatch_t  op, imm, robid, wa, tag (destination tag), rdy[1:0], src_tag[1:0], rdata[1:0]
- disp_full_r  out  1  no free entry; dispatch is not accepted
- cdb  in  cdb_t  CDB broadcast (vld, tag, wdata, robid, wa)
- iss_vld  out  1  an entry is ready for issue
- iss  out  issue_t  op, rdata[1:0], imm, tag, robid, wa of the selected entry
- iss_busy  in  1  execution unit cannot accept; hold issue
- occ_r  out  CNT_W  valid entry count

Behaviour:
- Reset:
  - All entries are invalid and the age matrix is cleared.
  - disp_full_r=0, occ_r=0, iss_vld=0, iss='0.
  - Reset mid-operation discards all entries. Nothing issues in the cycle after reset deasserts.
- Entry state: vld, op, imm, robid, wa, tag, rdy[1:0], src_tag[1:0], rdata[1:0].
- Allocation:
  - Dispatch is accepted when disp_vld & ~disp_full_r.
  - The accepted instruction is written to the lowest-index free entry at the clock edge.
  - disp_vld while disp_full_r is high is dropped. The bench flags this as a protocol error via assertion.
- Dispatch/CDB bypass:
  - Applies when disp.rdy[k]=0 and cdb.vld and cdb.tag==disp.src_tag[k] in the accepting cycle.
  - The entry is written with rdy[k]=1 and rdata[k]=cdb.wdata.
- Wakeup:
  - Applies to every valid entry i and operand k with rdy[k]=0 and src_tag[k]==cdb.tag while cdb.vld.
  - rdata[k] takes cdb.wdata and rdy[k] is set at the next edge.
  - All matching entries and operands capture in the same cycle.
- Unused operands (NOT, MOV0, MOV1, MOVI) arrive with rdy=1 from dispatch. The RS does no opcode decode.
- Ready: vld & rdy[0] & rdy[1], computed from registered state only.
  - An operand woken at edge t makes its entry issuable in cycle t+1. There is no same-cycle wakeup-to-issue path.
- Select:
  - Picks the oldest ready entry using an N x N age matrix.
  - On allocation of entry i: row i is cleared and column i is set for all other valid entries.
  - Ties are impossible by construction.
- Issue:
  - iss_vld = any entry ready; iss is the selected entry's fields, combinational from state.
  - iss is '0 when iss_vld=0.
  - Handshake: the transfer occurs when iss_vld & ~iss_busy; the selected entry is invalidated at that edge.
  - While iss_busy=1, the selection may change if an older entry becomes ready. Only the entry presented during the transfer cycle is freed.
- Occupancy:
  - occ_r next = occ_r + accept - transfer.
  - disp_full_r next = (occ_next == N), which makes it registered.
  - An entry freed at edge t can be reallocated in cycle t+1; there is no same-cycle reuse.
- Simultaneous accept, wakeup and issue in one cycle are all legal and independent. An entry allocated at edge t is never the one freed at edge t.

Decomposition:
- tomasulo_pkg:
  - adds dispatch_t (op, imm, robid, wa, tag, rdy[1:0], src_tag[1:0], rdata[1:0]) and RS_N_DEFAULT;
  - reuses issue_t, cdb_t, word_t, tag_t, opcode_t.
- Sub-module tomasulo_rs_age_matrix (N):
  - inputs: alloc one-hot, valid vector, request vector;
  - output: one-hot grant of the oldest requester;
  - contains the age matrix flops.
- A lowest-free-index priority encoder lives inline.

Test Plan:
- Ready dispatch: disp op=AND, rdata={0x3C,0xF0}, rdy=2'b11, tag=5, iss_busy=0.
  -> Next cycle: iss_vld=1, iss.tag=5, iss.rdata={0x3C,0xF0}, occ_r=1.
  -> Following cycle: iss_vld=0, occ_r=0.
- Wakeup: dispatch with rdy=2'b10, src_tag[0]=3; two cycles later cdb.vld=1, tag=3, wdata=0xAA.
  -> iss_vld=1 exactly one cycle after the CDB cycle, with iss.rdata[0]=0xAA.
  -> A non-matching CDB tag=4 beforehand causes no issue.
- Bypass: dispatch src_tag[1]=7 not ready in the same cycle as cdb tag=7, wdata=0x55.
  -> Issue next cycle with rdata[1]=0x55.
  -> The entry never waits for a later broadcast.
- Full/backpressure: N=4, iss_busy=1, four ready dispatches.
  -> disp_full_r=1 and occ_r=4 one cycle after the 4th; a 5th disp_vld is not accepted.
  -> Drop iss_busy: one entry freed per cycle, disp_full_r falls one cycle after the first transfer.
- Age order: dispatch A (entry 0, not ready), B (entry 1, ready), C (entry 2, ready); then wake A via CDB.
  -> B issues first, then A, then C, provided A becomes ready before C's turn.
  -> Refill of entry 1 is treated as youngest.
- Reset mid-operation: three valid entries, assert rst for one cycle.
  -> occ_r=0, disp_full_r=0, iss_vld=0 next cycle.
  -> A subsequent CDB matching an old src_tag causes no issue.
